// File: rtl/switch_char_sequencer.sv
// Two-button character sequencer: debounced pushbuttons step through an 8-entry
// message, either manually or by a periodic auto-scroll timer.
module switch_char_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned SCROLL_CYCLES   = 12500000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  output logic [7:0] o_Char,
  output logic       o_Char_Valid,
  output logic [2:0] o_Index,
  output logic       o_Auto
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned SC_W = (SCROLL_CYCLES > 1) ? $clog2(SCROLL_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCROLL_CYCLES - 1);

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } mode_t;

  function automatic logic [7:0] char_at(input logic [2:0] idx);
    case (idx)
      3'd0:    char_at = 8'h47;
      3'd1:    char_at = 8'h4F;
      3'd2:    char_at = 8'h2D;
      3'd3:    char_at = 8'h62;
      3'd4:    char_at = 8'h4F;
      3'd5:    char_at = 8'h41;
      3'd6:    char_at = 8'h72;
      default: char_at = 8'h64;
    endcase
  endfunction

  // Bit 0 = Switch_1 (advance), bit 1 = Switch_2 (mode toggle)
  logic [1:0]      raw;
  logic [1:0]      sync_1, sync_2;
  logic [1:0]      deb, deb_prev, press;
  logic [DB_W-1:0] db_cnt [2];

  assign raw = {i_Switch_2, i_Switch_1};

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync_1   <= '0;
      sync_2   <= '0;
      deb      <= '0;
      deb_prev <= '0;
      press    <= '0;
      for (int unsigned i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync_1   <= raw;
      sync_2   <= sync_1;
      deb_prev <= deb;
      press    <= deb & ~deb_prev;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync_2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync_2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  mode_t           state_q, state_d;
  logic [SC_W-1:0] timer_q, timer_d;
  logic            expire, advance;
  logic [2:0]      index_d;

  // A coinciding press and timer expiry are merged into one advance
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    expire  = (state_q == AUTO) && (timer_q == SC_LAST);
    advance = press[0] | expire;
    index_d = advance ? o_Index + 3'd1 : o_Index;
    if (press[1]) begin
      state_d = (state_q == AUTO) ? MANUAL : AUTO;
      timer_d = '0;
    end else if (state_q == MANUAL || advance) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q      <= MANUAL;
      timer_q      <= '0;
      o_Index      <= '0;
      o_Char       <= 8'h47;
      o_Char_Valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      o_Index      <= index_d;
      o_Char       <= char_at(index_d);
      o_Char_Valid <= advance;
    end
  end

  assign o_Auto = (state_q == AUTO);

endmodule

// File: tb/tb_switch_char_sequencer.sv
// Scoreboard bench for switch_char_sequencer with short debounce/scroll periods.
module tb_switch_char_sequencer;

  logic       clk;
  logic       rst_n;
  logic       sw1, sw2;
  logic [7:0] o_char;
  logic       o_valid;
  logic [2:0] o_index;
  logic       o_auto;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] ch;
  } exp_t;

  exp_t     sb[$];
  int       exp_idx = 0;
  logic [7:0] msg [8] = '{8'h47, 8'h4F, 8'h2D, 8'h62, 8'h4F, 8'h41, 8'h72, 8'h64};

  switch_char_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .SCROLL_CYCLES  (10)
  ) dut (
    .i_Clk       (clk),
    .i_Rst_L     (rst_n),
    .i_Switch_1  (sw1),
    .i_Switch_2  (sw2),
    .o_Char      (o_char),
    .o_Char_Valid(o_valid),
    .o_Index     (o_index),
    .o_Auto      (o_auto)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_next();
    exp_t e;
    exp_idx = (exp_idx + 1) % 8;
    e.idx = 3'(exp_idx);
    e.ch  = msg[exp_idx];
    sb.push_back(e);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!o_valid && n < 25);
    if (!o_valid) check("valid_timeout", 32'(o_valid), 32'd1);
  endtask

  task automatic wait_auto(input logic target);
    int n = 0;
    while (o_auto !== target && n < 25) begin
      tick();
      n++;
    end
    check("mode_wait", 32'(o_auto), 32'(target));
  endtask

  // Every valid pulse must match the oldest expected character
  always @(negedge clk) begin
    if (rst_n && o_valid) begin
      if (sb.size() == 0) begin
        check("unexp_valid", 32'(o_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_index", 32'(o_index), 32'(e.idx));
        check("sb_char", 32'(o_char), 32'(e.ch));
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    sw1 = 1'b0;
    sw2 = 1'b0;
    repeat (3) tick();
    check("rst_index", 32'(o_index), 32'd0);
    check("rst_char", 32'(o_char), 32'h47);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_auto", 32'(o_auto), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Latency: raw high before edge N gives the index update at edge N+7
    sw1 = 1'b1;
    push_next();
    repeat (7) tick();
    check("lat_before_idx", 32'(o_index), 32'd0);
    tick();
    check("lat_after_idx", 32'(o_index), 32'd1);
    check("lat_after_char", 32'(o_char), 32'h4F);
    check("lat_valid", 32'(o_valid), 32'd1);
    tick();
    check("valid_one_cycle", 32'(o_valid), 32'd0);
    repeat (20) tick();
    check("hold_no_repeat", 32'(o_index), 32'd1);
    sw1 = 1'b0;
    repeat (10) tick();

    // Short bounces must be rejected
    repeat (4) begin
      sw1 = 1'b1;
      repeat (3) tick();
      sw1 = 1'b0;
      repeat (3) tick();
    end
    repeat (10) tick();
    check("bounce_idx", 32'(o_index), 32'd1);

    // Manual presses: wrap to 0, then a full pass through the message
    repeat (15) begin
      push_next();
      sw1 = 1'b1;
      repeat (10) tick();
      sw1 = 1'b0;
      repeat (10) tick();
    end
    check("wrap_idx", 32'(o_index), 32'd0);
    check("wrap_char", 32'(o_char), 32'h47);

    // Auto mode: advance every 10 cycles, stop after toggling back
    sw2 = 1'b1;
    wait_auto(1'b1);
    sw2 = 1'b0;
    repeat (3) begin
      push_next();
      wait_valid(n);
      check("auto_period", 32'(n), 32'd10);
    end
    sw2 = 1'b1;
    wait_auto(1'b0);
    sw2 = 1'b0;
    repeat (30) tick();
    check("manual_stop_idx", 32'(o_index), 32'd3);

    // Press event landing on the expiry cycle advances once
    sw2 = 1'b1;
    wait_auto(1'b1);
    sw2 = 1'b0;
    push_next();
    wait_valid(n);
    check("auto2_first", 32'(n), 32'd10);
    push_next();
    repeat (2) tick();
    sw1 = 1'b1;
    wait_valid(n);
    check("coinc_gap", 32'(n), 32'd8);
    sw1 = 1'b0;
    push_next();
    wait_valid(n);
    check("after_coinc", 32'(n), 32'd10);
    check("after_coinc_idx", 32'(o_index), 32'd6);

    while (exp_idx != 5) begin
      push_next();
      wait_valid(n);
    end
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_index", 32'(o_index), 32'd0);
    check("midrst_char", 32'(o_char), 32'h47);
    check("midrst_auto", 32'(o_auto), 32'd0);
    check("midrst_valid", 32'(o_valid), 32'd0);
    sb.delete();
    exp_idx = 0;

    // Switch held through reset release counts as a fresh press
    sw1 = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    push_next();
    wait_valid(n);
    check("held_rst_idx", 32'(o_index), 32'd1);
    sw1 = 1'b0;
    repeat (10) tick();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_char_sequencer.md
SWITCH_CHAR_SEQUENCER -- requirements
Module: switch_char_sequencer

Interface
REQ-001 The block SHALL take parameter DEBOUNCE_CYCLES, default 250000, meaning the consecutive stable cycles needed to accept a switch level change (10 ms at 25 MHz).
REQ-002 The block SHALL take parameter SCROLL_CYCLES, default 12500000, meaning the auto-scroll advance period in clocks (0.5 s at 25 MHz).
REQ-003 The block SHALL have port i_Clk, input, 1 bit: the single system clock; all state is clocked on its rising edge.
REQ-004 The block SHALL have port i_Rst_L, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port i_Switch_1, input, 1 bit: raw, asynchronous, bouncing pushbutton used to advance the character.
REQ-006 The block SHALL have port i_Switch_2, input, 1 bit: raw, asynchronous, bouncing pushbutton used to toggle the mode.
REQ-007 The block SHALL have port o_Char, output, 8 bits: ASCII code of the current character, driven to the downstream character-segment decoder.
REQ-008 The block SHALL have port o_Char_Valid, output, 1 bit: one-cycle pulse on each o_Char change.
REQ-009 The block SHALL have port o_Index, output, 3 bits: current message position.
REQ-010 The block SHALL have port o_Auto, output, 1 bit: 1 = AUTO mode, 0 = MANUAL mode.

Function
REQ-011 The block SHALL pass each raw switch through its own two-flop synchronizer before any other use.
REQ-012 Per switch, the block SHALL hold a debounced level and a counter; the counter clears whenever the synced level equals the debounced level and otherwise increments; the debounced level flips on the edge on which the counter reaches DEBOUNCE_CYCLES-1 while the levels still differ, and the counter then clears.
REQ-013 A press event SHALL be a registered one-cycle pulse on each 0->1 transition of a debounced level; 1->0 transitions SHALL generate no event.
REQ-014 The message table SHALL be 8 entries, index 0..7: 0x47 'G', 0x4F 'O', 0x2D '-', 0x62 'b', 0x4F 'O', 0x41 'A', 0x72 'r', 0x64 'd'.
REQ-015 o_Char SHALL always equal table[o_Index]; both SHALL be registered and SHALL update on the same edge.
REQ-016 The index advance SHALL be (o_Index+1) mod 8, so 7 wraps to 0.
REQ-017 The FSM SHALL have two states: MANUAL (o_Auto=0) and AUTO (o_Auto=1); a Switch_2 press event toggles the state.
REQ-018 In MANUAL, each Switch_1 press event SHALL advance the index once; the scroll timer SHALL be held at 0.
REQ-019 In AUTO, the scroll timer SHALL count 0..SCROLL_CYCLES-1; on the cycle it equals SCROLL_CYCLES-1 the index SHALL advance and the timer SHALL return to 0.
REQ-020 In AUTO, a Switch_1 press event SHALL advance the index immediately and clear the timer.
REQ-021 When a timer expiry and a Switch_1 press coincide, the index SHALL advance exactly once.
REQ-022 On any mode change the scroll timer SHALL clear to 0.
REQ-023 When a Switch_2 press and a Switch_1 press occur in the same cycle, the mode SHALL toggle and the index SHALL advance exactly once.
REQ-024 o_Char_Valid SHALL be 1 for exactly the cycle following each index-update edge, and 0 otherwise.
REQ-025 Latency: a raw switch stable high from edge N SHALL yield the index update at edge N+2+DEBOUNCE_CYCLES+1.
REQ-026 Bounces shorter than DEBOUNCE_CYCLES SHALL produce no event.

Reset
REQ-027 Asserting i_Rst_L low SHALL immediately clear all state, including mid-debounce or mid-scroll state.
REQ-028 During reset: o_Index=0; o_Char=0x47; o_Char_Valid=0; o_Auto=0; debounced levels 0; counters and timer 0; synchronizer flops 0.
REQ-029 After reset release, a switch already held high SHALL be treated as a fresh press and be debounced normally.

Verification (DEBOUNCE_CYCLES=4, SCROLL_CYCLES=10)
REQ-030 Reset, then hold Switch_1 high -> o_Index 0->1 and o_Char 0x47->0x4F on the 7th edge; o_Char_Valid high for 1 cycle; holding produces no further advance.
REQ-031 Switch_1 toggling with high pulses of 3 cycles -> no index change, o_Char_Valid stays 0.
REQ-032 Eight clean Switch_1 presses from index 0 -> sequence G,O,-,b,O,A,r,d, then wraps to index 0 with o_Char=0x47.
REQ-033 Press Switch_2 -> o_Auto=1; the index then advances every 10 cycles; press Switch_2 again -> o_Auto=0 and advancing stops.
REQ-034 In AUTO, time a Switch_1 press event onto the timer-expiry cycle -> the index advances by exactly 1 and the next advance follows 10 cycles later.
REQ-035 In AUTO at index 5, assert i_Rst_L low mid-period -> outputs immediately index 0, 0x47, o_Auto=0, o_Char_Valid=0.
